// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU operation encodings, used by the decoder and the execute stage.
package alu_exec_stage_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/and/or/slt. Undefined codes give result 0 and flag illegal.
module alu_core
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);
    logic w_lt;

    // Signed compare is overflow-correct, unlike taking the sign of a-b.
    assign w_lt = $signed(src_a) < $signed(src_b);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_control)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = src_a - src_b;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_lt};
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready handshake and flush.
// Optional one-entry skid buffer (registered in_ready) under `ALU_EXEC_SKID_EN.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             illegal
);
    logic [WIDTH-1:0] w_res;
    logic             w_ill;
    logic             w_accept;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .result      (w_res),
        .illegal     (w_ill)
    );

    assign w_accept = in_valid && in_ready && !flush;

`ifdef ALU_EXEC_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_result;
    logic             r_skid_illegal;
    logic             r_in_ready;
    logic             w_out_free;

    assign w_out_free = !r_out_valid || out_ready;
    // r_in_ready tracks !skid_valid; reset gating keeps it low while reset is held.
    assign in_ready   = r_in_ready && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_result       <= '0;
            r_zero         <= 1'b1;
            r_illegal      <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_result  <= '0;
            r_skid_illegal <= 1'b0;
            r_in_ready     <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_free) begin
            // in_ready is low whenever the skid is full, so no accept can collide here.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_result     <= r_skid_result;
                r_zero       <= (r_skid_result == '0);
                r_illegal    <= r_skid_illegal;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_zero      <= (w_res == '0);
                r_illegal   <= w_ill;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid   <= 1'b1;
            r_skid_result  <= w_res;
            r_skid_illegal <= w_ill;
            r_in_ready     <= 1'b0;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_illegal   <= w_ill;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign out_valid  = r_out_valid;
    assign alu_result = r_result;
    assign zero       = r_zero;
    assign illegal    = r_illegal;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (both builds; skid checks under ALU_EXEC_SKID_EN).
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        zero;
    logic        illegal;

    int n_chk = 0;
    int n_fail = 0;

    logic [2:0]  s_ctl [8];
    logic [31:0] s_a   [8];
    logic [31:0] s_b   [8];
    logic [31:0] s_exp [8];

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero        (zero),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one op with out_ready=1 and check the registered outputs one cycle later.
    task automatic do_op(input string tag, input logic [2:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input logic ill);
        alu_control = ctl; src_a = a; src_b = b;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_v"}, 32'(out_valid), 32'd1);
        chk({tag, "_r"}, alu_result, res);
        chk({tag, "_z"}, 32'(zero), 32'(z));
        chk({tag, "_i"}, 32'(illegal), 32'(ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        stall;
        logic        acc;
        logic [31:0] held;
        int          k;
        int          oi;

        s_ctl[0] = 3'b000; s_a[0] = 32'd1;          s_b[0] = 32'd2;          s_exp[0] = 32'd3;
        s_ctl[1] = 3'b001; s_a[1] = 32'd10;         s_b[1] = 32'd3;          s_exp[1] = 32'd7;
        s_ctl[2] = 3'b010; s_a[2] = 32'hF0F0_F0F0;  s_b[2] = 32'hFF00_FF00;  s_exp[2] = 32'hF000_F000;
        s_ctl[3] = 3'b011; s_a[3] = 32'h0F00_0000;  s_b[3] = 32'h0000_00F0;  s_exp[3] = 32'h0F00_00F0;
        s_ctl[4] = 3'b101; s_a[4] = 32'hFFFF_FFFF;  s_b[4] = 32'd1;          s_exp[4] = 32'd1;
        s_ctl[5] = 3'b101; s_a[5] = 32'd1;          s_b[5] = 32'hFFFF_FFFF;  s_exp[5] = 32'd0;
        s_ctl[6] = 3'b000; s_a[6] = 32'h7FFF_FFFF;  s_b[6] = 32'd1;          s_exp[6] = 32'h8000_0000;
        s_ctl[7] = 3'b001; s_a[7] = 32'd0;          s_b[7] = 32'd1;          s_exp[7] = 32'hFFFF_FFFF;

        reset = 1'b1; in_valid = 1'b0; alu_control = 3'b000;
        src_a = '0; src_b = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", 32'(out_valid), 32'd0);
        chk("rst_r", alu_result, 32'd0);
        chk("rst_z", 32'(zero), 32'd1);
        chk("rst_i", 32'(illegal), 32'd0);
`ifdef ALU_EXEC_SKID_EN
        chk("rst_rdy", 32'(in_ready), 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("rel_rdy", 32'(in_ready), 32'd1);

        do_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        do_op("slt_ovf",  3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op("slt_eq",   3'b101, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);
        do_op("sub_neg",  3'b001, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("and",      3'b010, 32'hAAAA_5555, 32'h0FF0_0FF0, 32'h0AA0_0550, 1'b0, 1'b0);
        do_op("or",       3'b011, 32'hA000_0000, 32'h0000_0005, 32'hA000_0005, 1'b0, 1'b0);
        do_op("ill_110",  3'b110, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1'b1);
        do_op("ill_100",  3'b100, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1'b1);
        do_op("ill_111",  3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);

        // Streaming with out_ready pattern 1,0,0,1,...
        @(posedge clk); #1;
        k = 0; oi = 0; stall = 1'b0; held = '0;
        for (int c = 0; c < 80 && oi < 8; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            if (k < 8) begin
                in_valid = 1'b1; alu_control = s_ctl[k]; src_a = s_a[k]; src_b = s_b[k];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall) begin
                chk("hold_v", 32'(out_valid), 32'd1);
                chk("hold_r", alu_result, held);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d", oi), alu_result, s_exp[oi]);
                oi++;
            end
            stall = out_valid && !out_ready;
            held  = alu_result;
            @(posedge clk); #1;
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("stream_cnt", 32'(oi), 32'd8);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Flush while a result is held and a new bundle is presented.
        alu_control = 3'b000; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("fl_hold", alu_result, 32'd2);
        src_a = 32'h55; src_b = 32'd0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_v", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("fl_gone", 32'(out_valid), 32'd0);
        end

`ifdef ALU_EXEC_SKID_EN
        // Stall, accept one more into the skid, then drain both in order.
        alu_control = 3'b000; src_a = 32'd100; src_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("sk_rdy1", 32'(in_ready), 32'd1);
        src_a = 32'd200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("sk_rdy0", 32'(in_ready), 32'd0);
        chk("sk_a_hold", alu_result, 32'd101);
        out_ready = 1'b1;
        #1;
        chk("sk_a_v", 32'(out_valid), 32'd1);
        chk("sk_a", alu_result, 32'd101);
        @(posedge clk); #1;
        chk("sk_b_v", 32'(out_valid), 32'd1);
        chk("sk_b", alu_result, 32'd201);
        @(posedge clk); #1;
        chk("sk_empty", 32'(out_valid), 32'd0);
`else
        // in_ready follows out_ready combinationally while a result is held.
        alu_control = 3'b000; src_a = 32'd100; src_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("cr_rdy0", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("cr_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("cr_empty", 32'(out_valid), 32'd0);
`endif

        // Reset during a stall discards everything held.
        alu_control = 3'b000; src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        chk("rs_hold", alu_result, 32'd7);
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        chk("rs_v", 32'(out_valid), 32'd0);
        chk("rs_z", 32'(zero), 32'd1);
        chk("rs_r", alu_result, 32'd0);
        reset = 1'b0;
        #1;
        chk("rs_rdy", 32'(in_ready), 32'd1);
        do_op("post_rst", 3'b000, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("no_ghost", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
